// File: rtl/mem_boot_if.sv
// Bus bundle between the boot arbiter and its surroundings: UART byte
// stream, core memory request, shared memory port and status flags.
interface mem_boot_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  // rx_valid is a one-cycle strobe with no back-pressure: rx_data is
  // consumed on every cycle rx_valid is high. reload is a one-cycle pulse.
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              reload;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              ovf;
  logic [1:0]        state_dbg;

  modport slave (
    input  rx_data, rx_valid, reload, core_addr, core_wdata, core_we,
    output mem_addr, mem_wdata, mem_we, core_hold, busy, done, ovf, state_dbg
  );

  modport master (
    output rx_data, rx_valid, reload, core_addr, core_wdata, core_we,
    input  mem_addr, mem_wdata, mem_we, core_hold, busy, done, ovf, state_dbg
  );
endinterface

// File: rtl/mem_boot_arbiter.sv
// Arbitrates the unified memory port between a UART boot loader and the core.
// The loader packs big-endian bytes into words, then hands memory to the core.
module mem_boot_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  mem_boot_if.slave bus
);
  localparam int BPW    = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = $clog2(BPW + 1);
  localparam int WIDX_W = ADDR_W + 1;

  typedef enum logic [1:0] {WAIT_CNT, RX_BYTES, WRITE, RUN} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    byte_cnt, byte_cnt_n;
  logic [WIDX_W-1:0]   word_idx, word_idx_n;
  logic [WIDX_W-1:0]   n_words, n_words_n;
  logic [DATA_W-1:0]   pack, pack_n;
  logic                ovf_q, ovf_n;
  logic                done_q, done_n;
  logic [DATA_W-1:0]   shifted;

  assign shifted = (pack << 8) | DATA_W'(bus.rx_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAIT_CNT;
      byte_cnt <= '0;
      word_idx <= '0;
      n_words  <= '0;
      pack     <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      byte_cnt <= byte_cnt_n;
      word_idx <= word_idx_n;
      n_words  <= n_words_n;
      pack     <= pack_n;
      ovf_q    <= ovf_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    word_idx_n = word_idx;
    n_words_n  = n_words;
    pack_n     = pack;
    ovf_n      = ovf_q;
    case (state)
      WAIT_CNT: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'd0) begin
            state_n = RUN;
          end else begin
            if (int'(bus.rx_data) > DEPTH) begin
              n_words_n = WIDX_W'(DEPTH);
              ovf_n     = 1'b1;
            end else begin
              n_words_n = WIDX_W'(bus.rx_data);
            end
            word_idx_n = '0;
            byte_cnt_n = '0;
            state_n    = RX_BYTES;
          end
        end
      end
      RX_BYTES: begin
        if (bus.rx_valid) begin
          pack_n = shifted;
          if (byte_cnt == CNT_W'(BPW - 1)) begin
            byte_cnt_n = '0;
            state_n    = WRITE;
          end else begin
            byte_cnt_n = byte_cnt + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        word_idx_n = word_idx + WIDX_W'(1);
        if (word_idx == n_words - WIDX_W'(1)) begin
          state_n = RUN;
        end else begin
          state_n    = RX_BYTES;
          byte_cnt_n = '0;
          // A byte landing in this cycle is the first byte of the next word.
          if (bus.rx_valid) begin
            pack_n = shifted;
            if (BPW == 1) state_n = WRITE;
            else          byte_cnt_n = CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (bus.reload) begin
          state_n = WAIT_CNT;
          ovf_n   = 1'b0;
        end
      end
      default: state_n = WAIT_CNT;
    endcase
    done_n = (state_n == RUN) && (state != RUN);
  end

  // Loader-side memory outputs come straight from state/word_idx/pack flops.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    if (state == RUN) begin
      bus.mem_addr  = bus.core_addr;
      bus.mem_wdata = bus.core_wdata;
      bus.mem_we    = bus.core_we;
    end else if (state == WRITE) begin
      bus.mem_addr  = word_idx[ADDR_W-1:0];
      bus.mem_wdata = pack;
      bus.mem_we    = 1'b1;
    end
  end

  assign bus.core_hold = (state != RUN);
  assign bus.busy      = (state != RUN);
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_mem_boot_arbiter.sv
// Bench for mem_boot_arbiter: vector table of image loads plus hand-written
// sequences for exact write timing, reload behaviour and mid-load reset.
module tb_mem_boot_arbiter;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int BPW    = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_boot_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_boot_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int wr_cnt = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  typedef struct {
    logic [7:0] count;
    bit         b2b;
    bit         junk;
    bit         exp_ovf;
    int         exp_wr;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every loader write is popped and compared in order.
  always @(negedge clk) begin
    if (!rst && bus.core_hold && bus.mem_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h with empty queue",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        check("write", {bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put_byte(input logic [7:0] b, input bit hold);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) bus.rx_valid = 1'b0;
  endtask

  task automatic load_image(input logic [7:0] count, input bit b2b, input bit junk);
    int nw;
    logic [DATA_W-1:0] word;
    logic [7:0] b;
    nw = (int'(count) > DEPTH) ? DEPTH : int'(count);
    put_byte(count, b2b && nw > 0);
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int k = 0; k < BPW; k++) begin
        b = 8'($urandom_range(0, 255));
        word = {word[DATA_W-9:0], b};
        if (k == BPW - 1) exp_q.push_back({ADDR_W'(w), word});
        if (!b2b) idle($urandom_range(0, 2));
        put_byte(b, b2b);
      end
    end
    if (b2b && junk && nw > 0) put_byte(8'hEE, 1'b0);
    bus.rx_valid = 1'b0;
  endtask

  // done must rise exactly at the limit-th falling edge and last one cycle.
  task automatic check_done(input int limit);
    for (int i = 1; i < limit; i++) begin
      @(negedge clk);
      check("done_early", bus.done, 1'b0);
    end
    @(negedge clk);
    check("done_pulse", bus.done, 1'b1);
    check("hold_with_done", bus.core_hold, 1'b0);
    check("busy_with_done", bus.busy, 1'b0);
    @(negedge clk);
    check("done_one_cycle", bus.done, 1'b0);
  endtask

  task automatic do_reload();
    @(posedge clk); #1;
    bus.reload = 1'b1;
    @(posedge clk); #1;
    bus.reload = 1'b0;
    check("reload_hold", bus.core_hold, 1'b1);
    check("reload_busy", bus.busy, 1'b1);
    check("reload_ovf", bus.ovf, 1'b0);
    check("reload_state", bus.state_dbg, 2'd0);
  endtask

  initial begin
    vecs[0] = '{count: 8'd0,  b2b: 1'b0, junk: 1'b0, exp_ovf: 1'b0, exp_wr: 0};
    vecs[1] = '{count: 8'd20, b2b: 1'b0, junk: 1'b0, exp_ovf: 1'b1, exp_wr: 16};
    vecs[2] = '{count: 8'd3,  b2b: 1'b1, junk: 1'b1, exp_ovf: 1'b0, exp_wr: 3};
    vecs[3] = '{count: 8'd16, b2b: 1'b1, junk: 1'b0, exp_ovf: 1'b0, exp_wr: 16};
    vecs[4] = '{count: 8'd5,  b2b: 1'b0, junk: 1'b0, exp_ovf: 1'b0, exp_wr: 5};
    vecs[5] = '{count: 8'd17, b2b: 1'b1, junk: 1'b1, exp_ovf: 1'b1, exp_wr: 16};

    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.reload = 1'b0;
    bus.core_addr = '0; bus.core_wdata = '0; bus.core_we = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", bus.core_hold, 1'b1);
    check("rst_busy", bus.busy, 1'b1);
    check("rst_we", bus.mem_we, 1'b0);
    check("rst_addr", bus.mem_addr, '0);
    check("rst_wdata", bus.mem_wdata, '0);
    check("rst_done", bus.done, 1'b0);
    check("rst_ovf", bus.ovf, 1'b0);
    check("rst_state", bus.state_dbg, 2'd0);
    rst = 1'b0;
    idle(1);

    // Two-word image with exact write timing.
    exp_q.push_back({4'd0, 32'h11223344});
    exp_q.push_back({4'd1, 32'h55667788});
    put_byte(8'h02, 1'b0);
    put_byte(8'h11, 1'b0); put_byte(8'h22, 1'b0); put_byte(8'h33, 1'b0);
    put_byte(8'h44, 1'b0);
    @(negedge clk);
    check("w0_we", bus.mem_we, 1'b1);
    check("w0_addr", bus.mem_addr, 4'd0);
    check("w0_data", bus.mem_wdata, 32'h11223344);
    idle(1);
    put_byte(8'h55, 1'b0); put_byte(8'h66, 1'b0); put_byte(8'h77, 1'b0);
    put_byte(8'h88, 1'b0);
    @(negedge clk);
    check("w1_we", bus.mem_we, 1'b1);
    check("w1_addr", bus.mem_addr, 4'd1);
    check("w1_data", bus.mem_wdata, 32'h55667788);
    check_done(1);
    check("seq1_queue_empty", exp_q.size(), 0);
    check("seq1_ovf", bus.ovf, 1'b0);

    // Core owns the port in RUN: zero-latency pass-through.
    @(posedge clk); #1;
    bus.core_addr = 4'd5; bus.core_wdata = 32'hDEADBEEF; bus.core_we = 1'b1;
    #1;
    check("run_addr", bus.mem_addr, 4'd5);
    check("run_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("run_we", bus.mem_we, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.core_addr  = 4'($urandom_range(0, DEPTH - 1));
      bus.core_wdata = 32'($urandom());
      bus.core_we    = 1'($urandom_range(0, 1));
      #1;
      check("run_mirror", {bus.mem_addr, bus.mem_wdata, bus.mem_we},
            {bus.core_addr, bus.core_wdata, bus.core_we});
    end
    bus.core_we = 1'b0;

    // Vector table of image loads.
    for (int v = 0; v < 6; v++) begin
      do_reload();
      wr_cnt = 0;
      load_image(vecs[v].count, vecs[v].b2b, vecs[v].junk);
      check_done((vecs[v].count == 0 || vecs[v].junk) ? 1 : 2);
      check("vec_writes", wr_cnt, vecs[v].exp_wr);
      check("vec_ovf", bus.ovf, vecs[v].exp_ovf);
      check("vec_queue_empty", exp_q.size(), 0);
    end

    // Reload mid-load is ignored.
    do_reload();
    wr_cnt = 0;
    exp_q.push_back({4'd0, 32'hA1B2C3D4});
    put_byte(8'h01, 1'b0);
    put_byte(8'hA1, 1'b0); put_byte(8'hB2, 1'b0);
    bus.reload = 1'b1;
    @(posedge clk); #1;
    bus.reload = 1'b0;
    check("reload_rx_state", bus.state_dbg, 2'd1);
    check("reload_rx_hold", bus.core_hold, 1'b1);
    put_byte(8'hC3, 1'b0); put_byte(8'hD4, 1'b0);
    check_done(2);
    check("reload_rx_writes", wr_cnt, 1);

    // Asynchronous reset after two bytes of word 1.
    do_reload();
    wr_cnt = 0;
    exp_q.push_back({4'd0, 32'h01020304});
    put_byte(8'h02, 1'b0);
    put_byte(8'h01, 1'b0); put_byte(8'h02, 1'b0); put_byte(8'h03, 1'b0);
    put_byte(8'h04, 1'b0);
    idle(1);
    put_byte(8'h05, 1'b0); put_byte(8'h06, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_hold", bus.core_hold, 1'b1);
    check("mid_rst_we", bus.mem_we, 1'b0);
    check("mid_rst_state", bus.state_dbg, 2'd0);
    check("mid_rst_busy", bus.busy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_writes", wr_cnt, 1);
    wr_cnt = 0;
    exp_q.push_back({4'd0, 32'hAABBCCDD});
    put_byte(8'h01, 1'b0);
    put_byte(8'hAA, 1'b0); put_byte(8'hBB, 1'b0); put_byte(8'hCC, 1'b0);
    put_byte(8'hDD, 1'b0);
    check_done(2);
    check("fresh_writes", wr_cnt, 1);
    check("fresh_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mem_boot_arbiter.md
Name: mem_boot_arbiter

Overview:
- Owns the single unified instruction/data memory port of the multicycle MIPS core and arbitrates it between two masters: a UART boot loader and the running core.
- After reset it holds the core stalled, receives a program image byte-by-byte from the UART receiver, packs the bytes into 32-bit words and writes them to memory.
- When the image is complete it hands the memory port to the core and releases it.
- A reload request returns memory ownership to the loader.

Parameters:
ADDR_W, 4, word-address width of the memory port; depth DEPTH = 2^ADDR_W words.
DATA_W, 32, memory word width; must be a multiple of 8; BPW = DATA_W/8 bytes per word.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
rx_data  input  8  byte from UART receiver
rx_valid  input  1  one-cycle strobe, rx_data valid
reload  input  1  one-cycle pulse, request new image load
core_addr  input  ADDR_W  core memory word address
core_wdata  input  DATA_W  core write data
core_we  input  1  core write enable
mem_addr  output  ADDR_W  address to memory
mem_wdata  output  DATA_W  write data to memory
mem_we  output  1  write enable to memory
core_hold  output  1  high = core held in reset/stall
busy  output  1  high while loader owns memory
done  output  1  one-cycle pulse, image load complete
ovf  output  1  sticky: requested word count exceeded DEPTH

Behaviour:
- Reset (async, any state, including mid-load):
  - state=WAIT_CNT; core_hold=1, busy=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, ovf=0.
  - Byte counter, word index and packing register are cleared; partially received bytes are discarded.
  - Words already written stay in memory.
- States: WAIT_CNT, RX_BYTES, WRITE, RUN.
- WAIT_CNT, on rx_valid: rx_data is the word count N.
  - N=0: go to RUN (no writes).
  - N>DEPTH: load DEPTH words and set ovf=1.
  - Otherwise load N words. Then go to RX_BYTES with word_idx=0, byte_cnt=0.
- RX_BYTES, on each rx_valid:
  - Shift the byte into the packing register, big-endian: first byte lands in bits [DATA_W-1:DATA_W-8].
  - byte_cnt increments. On the BPW-th byte, go to WRITE.
- WRITE lasts exactly one cycle, the cycle after the last byte's rx_valid:
  - mem_we=1, mem_addr=word_idx, mem_wdata=packed word.
  - word_idx increments. If word_idx was N-1, go to RUN; else go to RX_BYTES with byte_cnt=0.
  - An rx_valid arriving in the WRITE cycle is captured as byte 0 of the next word and is not lost. Any further bytes in the last word's WRITE cycle are ignored.
- Entering RUN (the cycle after the final WRITE, or the cycle after the count byte when N=0):
  - done=1 for exactly one cycle; core_hold=0 and busy=0 in that same cycle.
- RUN:
  - mem_addr=core_addr, mem_wdata=core_wdata, mem_we=core_we, combinationally (zero latency).
  - rx_valid is ignored by the arbiter.
- Loader states: memory outputs are registered; core_we is ignored.
- reload:
  - Honoured only in RUN. Next cycle: state=WAIT_CNT, core_hold=1, busy=1, ovf cleared.
  - Ignored in any other state.
- word_idx is ADDR_W+1 bits wide so that a count of DEPTH terminates without wrap-around. mem_addr uses its low ADDR_W bits.

Test Plan:
- Reset, send 0x02 then 11 22 33 44 55 66 77 88 -> mem_we pulses twice (addr 0 data 0x11223344, addr 1 data 0x55667788), each the cycle after the 4th byte; done one cycle after the 2nd write; core_hold falls with done.
- Send count 0x00 -> no mem_we; done, core_hold=0, busy=0 on the next cycle; ovf=0.
- Send count 0x14 (20) with DEPTH=16 -> ovf=1; exactly 16 writes at addr 0..15; then RUN.
- Back-to-back rx_valid every cycle, including during each WRITE cycle -> no bytes lost; words match the input stream in order.
- In RUN drive core_addr=5, core_wdata=0xDEADBEEF, core_we=1 -> mem outputs mirror them in the same cycle. Pulse reload -> core_hold=1 next cycle; reload pulsed in RX_BYTES -> no effect.
- Assert rst after 2 bytes of word 1 -> core_hold=1, mem_we=0 immediately. A fresh load with count 0x01 then AA BB CC DD -> write addr 0 data 0xAABBCCDD.
